rom_loader: RTL and testbench

- Program downloader directly upstream of the instruction ROM's write port.
- Consumes a byte stream from the UART receiver, checks a framing header, and assembles little-endian 32-bit instructions.
- Issues one ROM write per word at incrementing word-aligned addresses.
- Holds the core in reset while downloading; reports completion or error.

---
 rtl/rom_loader_pkg.sv | 34 +++
 rtl/rom_loader_if.sv | 31 +++
 rtl/rom_loader_word_packer.sv | 71 +++++++
 rtl/rom_loader.sv | 166 ++++++++++++++++
 tb/tb_rom_loader.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rom_loader_pkg
// Purpose  : Shared definitions for the ROM program downloader: FSM state
//            encoding, frame start marker, default widths and a capacity
//            helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rom_loader_pkg;

  localparam int LDR_RV32_ADDR_WIDTH = 32;
  localparam int LDR_ROM_ADDR_WIDTH  = 12;

  localparam logic [7:0] LDR_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    LDR_IDLE = 3'd0,
    LDR_LEN0 = 3'd1,
    LDR_LEN1 = 3'd2,
    LDR_DATA = 3'd3,
    LDR_CSUM = 3'd4,
    LDR_DONE = 3'd5,
    LDR_ERR  = 3'd6
  } ldr_state_t;

  // ROM capacity in 32-bit words. Seventeen bits so that a full 16-bit word
  // count can be compared against it without wrapping.
  function automatic logic [16:0] ldr_max_words(input int rom_addr_width);
    return 17'(1) << (rom_addr_width - 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rom_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : rom_loader_if
// Purpose  : Byte stream from the UART receiver plus the instruction ROM
//            write port, bundled for the downloader.
// Signals  : rx_valid_i / rx_data_i - incoming byte strobe and byte
//            wr_en_o / wr_addr_o / wr_data_o - ROM write port
// Modports : slave  - the downloader (consumes bytes, drives the ROM port)
//            master - the environment (drives bytes, observes the ROM port)
// Revision : 1.0 - initial release
// ============================================================================
interface rom_loader_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  rx_valid_i;
  logic [7:0]            rx_data_i;
  logic                  wr_en_o;
  logic [ADDR_WIDTH-1:0] wr_addr_o;
  logic [31:0]           wr_data_o;

  modport slave (
    input  rx_valid_i, rx_data_i,
    output wr_en_o, wr_addr_o, wr_data_o
  );

  modport master (
    output rx_valid_i, rx_data_i,
    input  wr_en_o, wr_addr_o, wr_data_o
  );
endinterface
`default_nettype wire

// File: rtl/rom_loader_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : ldr_word_packer
// Purpose  : Gathers payload bytes little-endian into 32-bit words and issues
//            one registered ROM write per completed word at word_idx*4.
// Ports    : clk, rst_n       - clock, asynchronous active-low reset
//            clear            - restart lane and word counters (frame start)
//            accept, data     - payload byte strobe and value
//            lane_full        - the next accepted byte completes a word
//            word_idx         - index of the word currently being assembled
//            wr_en/addr/data  - ROM write pulse; addr/data hold between writes
// Revision : 1.0 - initial release
// ============================================================================
module ldr_word_packer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int ROM_ADDR_WIDTH = 12
) (
  input  wire logic                      clk,
  input  wire logic                      rst_n,
  input  wire logic                      clear,
  input  wire logic                      accept,
  input  wire logic [7:0]                data,
  output logic                           lane_full,
  output logic [ROM_ADDR_WIDTH-2:0]      word_idx,
  output logic                           wr_en,
  output logic [ADDR_WIDTH-1:0]          wr_addr,
  output logic [31:0]                    wr_data
);

  logic [1:0]                r_lane;
  logic [23:0]               r_shift;     // first three bytes of the word
  logic [ROM_ADDR_WIDTH-2:0] r_word_idx;  // one spare bit: counts to capacity
  logic                      r_wr_en;
  logic [ADDR_WIDTH-1:0]     r_wr_addr;
  logic [31:0]               r_wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane     <= 2'd0;
      r_shift    <= 24'd0;
      r_word_idx <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= 32'd0;
    end else begin
      r_wr_en <= 1'b0;
      if (clear) begin
        r_lane     <= 2'd0;
        r_word_idx <= '0;
      end else if (accept) begin
        r_lane  <= r_lane + 2'd1;
        // Shift from the top so byte 0 ends up in the least significant lane.
        r_shift <= {data, r_shift[23:8]};
        if (r_lane == 2'd3) begin
          r_wr_en    <= 1'b1;
          r_wr_data  <= {data, r_shift};
          r_wr_addr  <= ADDR_WIDTH'({r_word_idx, 2'b00});
          r_word_idx <= r_word_idx + 1'b1;
        end
      end
    end
  end

  assign lane_full = (r_lane == 2'd3);
  assign word_idx  = r_word_idx;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;

endmodule
`default_nettype wire

// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : rom_loader
// Purpose  : Program downloader in front of the instruction ROM write port.
//            Parses SYNC / LEN_LO / LEN_HI / payload / CSUM frames, writes
//            little-endian words at incrementing word addresses and holds
//            the core in reset until a frame completes cleanly.
// Ports    : clk, rst_n   - clock, asynchronous active-low reset
//            bus (slave)  - rx byte stream in, ROM write port out
//            cpu_hold_o   - core held in reset
//            busy_o       - frame in progress
//            done_o       - one-cycle pulse, good frame
//            err_o        - one-cycle pulse, oversize/bad checksum/timeout
// Revision : 1.0 - initial release
// ============================================================================
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH     = LDR_RV32_ADDR_WIDTH,
  parameter int         ROM_ADDR_WIDTH = LDR_ROM_ADDR_WIDTH,
  parameter logic [7:0] SYNC_BYTE      = LDR_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  rom_loader_if.slave   bus,
  output logic          cpu_hold_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  localparam int              GAP_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]     MAX_WORDS = ldr_max_words(ROM_ADDR_WIDTH);

  ldr_state_t                r_state;
  logic [15:0]               r_len;
  logic [7:0]                r_csum;
  logic [GAP_W-1:0]          r_gap;
  logic                      r_busy;
  logic                      r_hold;
  logic                      r_done;
  logic                      r_err;

  logic                      w_active;
  logic                      w_start;
  logic                      w_accept;
  logic                      w_last_byte;
  logic                      w_timeout;
  logic [16:0]               w_len_full;
  logic                      w_lane_full;
  logic [ROM_ADDR_WIDTH-2:0] w_word_idx;

  assign w_active   = (r_state == LDR_LEN0) || (r_state == LDR_LEN1) ||
                      (r_state == LDR_DATA) || (r_state == LDR_CSUM);
  assign w_start    = bus.rx_valid_i && (r_state == LDR_IDLE) && (bus.rx_data_i == SYNC_BYTE);
  assign w_accept   = bus.rx_valid_i && (r_state == LDR_DATA);
  assign w_timeout  = w_active && !bus.rx_valid_i && (r_gap == GAP_LIMIT);
  assign w_len_full = {1'b0, bus.rx_data_i, r_len[7:0]};
  // The byte completing word N-1 ends the payload; the write itself lands
  // one cycle later, overlapping the checksum byte.
  assign w_last_byte = w_accept && w_lane_full && (16'(w_word_idx) == (r_len - 16'd1));

  ldr_word_packer #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .ROM_ADDR_WIDTH (ROM_ADDR_WIDTH)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (w_start),
    .accept    (w_accept),
    .data      (bus.rx_data_i),
    .lane_full (w_lane_full),
    .word_idx  (w_word_idx),
    .wr_en     (bus.wr_en_o),
    .wr_addr   (bus.wr_addr_o),
    .wr_data   (bus.wr_data_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LDR_IDLE;
      r_len   <= 16'd0;
      r_csum  <= 8'd0;
      r_gap   <= '0;
      r_busy  <= 1'b0;
      r_hold  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;

      if (w_active && !bus.rx_valid_i) r_gap <= r_gap + 1'b1;
      else                             r_gap <= '0;

      if (w_timeout) begin
        r_state <= LDR_ERR;
        r_err   <= 1'b1;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          LDR_IDLE: begin
            if (w_start) begin
              r_state <= LDR_LEN0;
              r_busy  <= 1'b1;
              r_hold  <= 1'b1;
              r_csum  <= 8'd0;
            end
          end
          LDR_LEN0: begin
            if (bus.rx_valid_i) begin
              r_len[7:0] <= bus.rx_data_i;
              r_state    <= LDR_LEN1;
            end
          end
          LDR_LEN1: begin
            if (bus.rx_valid_i) begin
              r_len[15:8] <= bus.rx_data_i;
              if (w_len_full > MAX_WORDS) begin
                r_state <= LDR_ERR;
                r_err   <= 1'b1;
                r_busy  <= 1'b0;
              end else if (w_len_full == 17'd0) begin
                r_state <= LDR_CSUM;
              end else begin
                r_state <= LDR_DATA;
              end
            end
          end
          LDR_DATA: begin
            if (bus.rx_valid_i) begin
              r_csum <= r_csum + bus.rx_data_i;
              if (w_last_byte) r_state <= LDR_CSUM;
            end
          end
          LDR_CSUM: begin
            if (bus.rx_valid_i) begin
              r_busy <= 1'b0;
              if (bus.rx_data_i == r_csum) begin
                r_state <= LDR_DONE;
                r_done  <= 1'b1;
                r_hold  <= 1'b0;
              end else begin
                r_state <= LDR_ERR;
                r_err   <= 1'b1;
              end
            end
          end
          // Single-cycle reporting states; any byte arriving now is dropped.
          LDR_DONE: r_state <= LDR_IDLE;
          LDR_ERR:  r_state <= LDR_IDLE;
          default:  r_state <= LDR_IDLE;
        endcase
      end
    end
  end

  assign cpu_hold_o = r_hold;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign err_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_loader
// Purpose  : Self-checking bench for rom_loader: fixed frame table, hand
//            sequences for timeout / oversize / async reset, and random
//            frames checked against a frame-level reference model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_loader;

  logic clk;
  logic rst_n;
  logic cpu_hold_o;
  logic busy_o;
  logic done_o;
  logic err_o;

  rom_loader_if #(.ADDR_WIDTH(32)) bus ();

  rom_loader #(
    .ADDR_WIDTH     (32),
    .ROM_ADDR_WIDTH (12),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cpu_hold_o (cpu_hold_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  // Observations gathered on the falling edge.
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  int          done_cnt;
  int          err_cnt;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wr_en_o) begin
        got_addr.push_back(bus.wr_addr_o);
        got_data.push_back(bus.wr_data_o);
      end
      if (done_o) done_cnt++;
      if (err_o)  err_cnt++;
    end
  end

  typedef struct packed {
    logic [7:0]         nbytes;
    logic [0:15][7:0]   bytes;
    logic [7:0]         exp_wr;
    logic [0:1][31:0]   exp_data;
    logic               exp_done;
    logic               exp_err;
    logic               exp_hold;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = b;
    @(posedge clk); #1;
    bus.rx_valid_i = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_obs();
    got_addr.delete();
    got_data.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_wr_count"}, 64'(got_data.size()), 64'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < got_data.size(); j++) begin
      check({tag, "_wr_addr"}, 64'(got_addr[j]), 64'(j * 4));
      check({tag, "_wr_data"}, 64'(got_data[j]), 64'(exp_q[j]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    bit          seen;
    int          ng;
    int          n;
    int          gap;
    bit          good;
    logic [7:0]  b;
    logic [7:0]  sum;
    logic [31:0] w;

    tests = 0;
    fails = 0;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    clear_obs();

    vecs[0] = '{nbytes: 8'd12,
                bytes: {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93,
                        8'h00, 8'h10, 8'h00, 8'hB6, {4{8'h00}}},
                exp_wr: 8'd2, exp_data: {32'h0000_0013, 32'h0010_0093},
                exp_done: 1'b1, exp_err: 1'b0, exp_hold: 1'b0};
    vecs[1] = '{nbytes: 8'd12,
                bytes: {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93,
                        8'h00, 8'h10, 8'h00, 8'hB7, {4{8'h00}}},
                exp_wr: 8'd2, exp_data: {32'h0000_0013, 32'h0010_0093},
                exp_done: 1'b0, exp_err: 1'b1, exp_hold: 1'b1};
    vecs[2] = '{nbytes: 8'd4,
                bytes: {8'hA5, 8'h00, 8'h00, 8'h00, {12{8'h00}}},
                exp_wr: 8'd0, exp_data: {32'h0, 32'h0},
                exp_done: 1'b1, exp_err: 1'b0, exp_hold: 1'b0};
    vecs[3] = '{nbytes: 8'd3,
                bytes: {8'hA5, 8'h01, 8'h04, {13{8'h00}}},
                exp_wr: 8'd0, exp_data: {32'h0, 32'h0},
                exp_done: 1'b0, exp_err: 1'b1, exp_hold: 1'b1};
    vecs[4] = '{nbytes: 8'd7,
                bytes: {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00, {9{8'h00}}},
                exp_wr: 8'd0, exp_data: {32'h0, 32'h0},
                exp_done: 1'b1, exp_err: 1'b0, exp_hold: 1'b0};

    // Reset state
    rst_n = 1'b0;
    idle(3);
    check("rst_hold",    64'(cpu_hold_o),    64'd0);
    check("rst_busy",    64'(busy_o),        64'd0);
    check("rst_done",    64'(done_o),        64'd0);
    check("rst_err",     64'(err_o),         64'd0);
    check("rst_wr_en",   64'(bus.wr_en_o),   64'd0);
    check("rst_wr_addr", 64'(bus.wr_addr_o), 64'd0);
    check("rst_wr_data", 64'(bus.wr_data_o), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // busy/hold rise the cycle after SYNC
    clear_obs();
    send(8'hA5, 0);
    check("sync_busy", 64'(busy_o),     64'd1);
    check("sync_hold", 64'(cpu_hold_o), 64'd1);
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    check("empty_done_now", 64'(done_o), 64'd1);
    check("empty_busy_now", 64'(busy_o), 64'd0);
    idle(3);
    check("empty_done_cnt", 64'(done_cnt),   64'd1);
    check("empty_hold",     64'(cpu_hold_o), 64'd0);

    // Table-driven frames, back-to-back bytes
    for (int i = 0; i < 5; i++) begin
      clear_obs();
      exp_q.delete();
      for (int k = 0; k < int'(vecs[i].exp_wr); k++) exp_q.push_back(vecs[i].exp_data[k]);
      for (int k = 0; k < int'(vecs[i].nbytes); k++) send(vecs[i].bytes[k], 0);
      idle(4);
      check_writes($sformatf("vec%0d", i));
      check($sformatf("vec%0d_done", i), 64'(done_cnt),   64'(vecs[i].exp_done));
      check($sformatf("vec%0d_err", i),  64'(err_cnt),    64'(vecs[i].exp_err));
      check($sformatf("vec%0d_hold", i), 64'(cpu_hold_o), 64'(vecs[i].exp_hold));
    end

    // Oversize length: error visible right after LEN_HI
    clear_obs();
    send(8'hA5, 0); send(8'h01, 0); send(8'h04, 0);
    check("oversize_err_now", 64'(err_o),  64'd1);
    check("oversize_busy",    64'(busy_o), 64'd0);
    idle(3);
    check("oversize_wr", 64'(got_data.size()), 64'd0);

    // Timeout in DATA after one payload byte
    clear_obs();
    send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0); send(8'h13, 0);
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (err_o) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    check("timeout_seen",  64'(seen), 64'd1);
    check("timeout_lat_ok", 64'(lat >= 15 && lat <= 18), 64'd1);
    @(posedge clk); #1;
    idle(2);
    check("timeout_busy", 64'(busy_o),          64'd0);
    check("timeout_hold", 64'(cpu_hold_o),      64'd1);
    check("timeout_wr",   64'(got_data.size()), 64'd0);
    clear_obs();
    exp_q.delete();
    exp_q.push_back(32'h0000_0013);
    exp_q.push_back(32'h0010_0093);
    for (int k = 0; k < 12; k++) send(vecs[0].bytes[k], 0);
    idle(4);
    check_writes("after_timeout");
    check("after_timeout_done", 64'(done_cnt),   64'd1);
    check("after_timeout_hold", 64'(cpu_hold_o), 64'd0);

    // Random frames against the frame-level model
    for (int f = 0; f < 25; f++) begin
      clear_obs();
      exp_q.delete();
      gap = $urandom_range(0, 2);
      ng  = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h3C;
        send(b, gap);
      end
      n = $urandom_range(0, 6);
      send(8'hA5, gap);
      send(8'(n), gap);
      send(8'h00, gap);
      sum = 8'd0;
      for (int wi = 0; wi < n; wi++) begin
        w = $urandom;
        exp_q.push_back(w);
        for (int k = 0; k < 4; k++) begin
          sum = sum + w[8*k +: 8];
          send(w[8*k +: 8], gap);
        end
      end
      good = ($urandom_range(0, 3) != 0);
      send(good ? sum : sum + 8'($urandom_range(1, 255)), 0);
      idle(4);
      check_writes($sformatf("rnd%0d", f));
      check($sformatf("rnd%0d_done", f), 64'(done_cnt),   64'(good));
      check($sformatf("rnd%0d_err", f),  64'(err_cnt),    64'(!good));
      check($sformatf("rnd%0d_hold", f), 64'(cpu_hold_o), 64'(!good));
    end

    // Asynchronous reset mid-DATA
    clear_obs();
    for (int k = 0; k < 8; k++) send(vecs[0].bytes[k], 0);
    check("pre_rst_hold", 64'(cpu_hold_o),    64'd1);
    check("pre_rst_data", 64'(bus.wr_data_o), 64'h13);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_hold",    64'(cpu_hold_o),    64'd0);
    check("arst_busy",    64'(busy_o),        64'd0);
    check("arst_done",    64'(done_o),        64'd0);
    check("arst_err",     64'(err_o),         64'd0);
    check("arst_wr_en",   64'(bus.wr_en_o),   64'd0);
    check("arst_wr_addr", 64'(bus.wr_addr_o), 64'd0);
    check("arst_wr_data", 64'(bus.wr_data_o), 64'd0);
    @(posedge clk); #1;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    clear_obs();
    for (int k = 0; k < 4; k++) send(vecs[2].bytes[k], 0);
    idle(3);
    check("post_rst_done", 64'(done_cnt),        64'd1);
    check("post_rst_wr",   64'(got_data.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
